// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   localparam int unsigned FETCH_WORD_BYTES = 4;

   function automatic logic [31:0] fetch_word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_credit_cnt.sv
// Up/down counter saturating at 0 and MAX, with load priority; inc+dec together hold.
// Latency: one cycle from inc/dec/load to cnt_o; no backpressure.
module fetch_credit_cnt #(
   parameter int unsigned W       = 2,
   parameter int unsigned MAX     = 3,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && !dec_i && (cnt_q < W'(MAX))) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Prefetch sequencer: word requests, response push with PC, redirect flush; FETCH_CTRL_PERF_EN adds perf counters.
// Latency: push combinational with rvalid, new-target request the cycle after redirect; buffer credits throttle requests.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ENTRY           = 3,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h1000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_en_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        buf_push_o,
   output logic [31:0] buf_instr_o,
   output logic [31:0] buf_pc_o,
   output logic        buf_skip_lo_o,
   output logic        buf_clear_o,
   input  logic        buf_release_i,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_drop_cnt_o
);

   localparam int unsigned CW = $clog2(ENTRY + 1);
   localparam int unsigned OW = 2;

   fetch_state_e  state_d, state_q;
   logic [31:0]   fetch_addr_d, fetch_addr_q;
   logic [31:0]   rsp_pc_d, rsp_pc_q;
   logic          skip_d, skip_q;
   logic          pend_d, pend_q;
   logic          new_req, grant, rsp_accept;
   logic [CW-1:0] credit_cnt;
   logic [OW-1:0] out_cnt, discard_cnt, live_cnt, discard_load;

   assign grant      = imem_req_o & imem_gnt_i;
   // A response with nothing outstanding is a leftover from before reset.
   assign rsp_accept = imem_rvalid_i & (out_cnt != '0);
   assign live_cnt   = out_cnt - discard_cnt;
   assign discard_load = out_cnt + OW'(grant) - OW'(rsp_accept);

   assign buf_clear_o   = redirect_i;
   assign buf_push_o    = rsp_accept & (discard_cnt == '0) & !redirect_i;
   assign buf_instr_o   = imem_rdata_i;
   assign buf_pc_o      = rsp_pc_q;
   assign buf_skip_lo_o = skip_q & buf_push_o;
   assign imem_addr_o   = fetch_addr_q;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      rsp_pc_d     = rsp_pc_q;
      skip_d       = skip_q;
      new_req      = (state_q == RUN) && fetch_en_i && (credit_cnt != '0) &&
                     (out_cnt < OW'(MAX_OUTSTANDING)) && !redirect_i;
      // A raised request is held until granted; only a redirect abandons it.
      imem_req_o   = pend_q | new_req;
      pend_d       = imem_req_o & !imem_gnt_i & !redirect_i;

      case (state_q)
         IDLE:    if (fetch_en_i) state_d = RUN;
         RUN:     if (!fetch_en_i && !imem_req_o && (live_cnt == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (redirect_i) begin
         fetch_addr_d = fetch_word_align(redirect_pc_i);
         rsp_pc_d     = fetch_word_align(redirect_pc_i);
         skip_d       = redirect_pc_i[1];
      end else begin
         if (grant)      fetch_addr_d = fetch_addr_q + 32'(FETCH_WORD_BYTES);
         if (buf_push_o) begin
            rsp_pc_d = rsp_pc_q + 32'(FETCH_WORD_BYTES);
            skip_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fetch_addr_q <= fetch_word_align(RESET_PC);
         rsp_pc_q     <= fetch_word_align(RESET_PC);
         skip_q       <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         rsp_pc_q     <= rsp_pc_d;
         skip_q       <= skip_d;
         pend_q       <= pend_d;
      end
   end

   fetch_credit_cnt #(.W(CW), .MAX(ENTRY), .RST_VAL(CW'(ENTRY))) u_credit (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (redirect_i),
      .load_val_i (CW'(ENTRY)),
      .inc_i      (buf_release_i),
      .dec_i      (grant),
      .cnt_o      (credit_cnt)
   );

   // Total in-flight count, live plus discarded.
   fetch_credit_cnt #(.W(OW), .MAX(MAX_OUTSTANDING), .RST_VAL('0)) u_outstanding (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (grant),
      .dec_i      (rsp_accept),
      .cnt_o      (out_cnt)
   );

   fetch_credit_cnt #(.W(OW), .MAX(3), .RST_VAL('0)) u_discard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (redirect_i),
      .load_val_i (discard_load),
      .inc_i      (1'b0),
      .dec_i      (rsp_accept & (discard_cnt != '0)),
      .cnt_o      (discard_cnt)
   );

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetch_d, perf_fetch_q;
   logic [31:0] perf_drop_d, perf_drop_q;
   logic        drop;

   assign drop = rsp_accept & ((discard_cnt != '0) | redirect_i);

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(buf_push_o);
      perf_drop_d  = perf_drop_q + 32'(drop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_fetch_q <= '0;
         perf_drop_q  <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_drop_q  <= perf_drop_d;
      end
   end

   assign perf_fetch_cnt_o = perf_fetch_q;
   assign perf_drop_cnt_o  = perf_drop_q;
`else
   assign perf_fetch_cnt_o = '0;
   assign perf_drop_cnt_o  = '0;
`endif

endmodule
